// File: rtl/sys_defs.sv
// Shared machine-wide definitions: superscalar width, queue depth and the
// decoded-instruction packet passed from fetch/decode toward rename.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef N_IQ
`define N_IQ 8
`endif

package sys_defs;

  localparam int N_WAY = `N_WAY;
  localparam int N_IQ  = `N_IQ;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
  } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/lead_ones_count.sv
// Counts the contiguous run of ones in a mask starting at bit 0; bits after
// the first zero are ignored.
module lead_ones_count #(
  parameter int W = 2
) (
  input  logic [W-1:0]      mask,
  output logic [$clog2(W):0] count
);

  localparam int CW = $clog2(W) + 1;

  logic run;

  // NOTE: combinational blocks use blocking assignments with every output
  // defaulted first, so the loop reads its own running values and no latch forms.
  always_comb begin
    count = '0;
    run   = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & mask[i];
      if (run) count = count + CW'(1);
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// Circular instruction queue between fetch/decode and rename: accepts whole
// fetch groups when room allows and presents the oldest N_WAY entries.
module dispatch_queue
  import sys_defs::DISPATCH_PACKET_R10K;
#(
  parameter int N_WAY = sys_defs::N_WAY,
  parameter int N_IQ  = sys_defs::N_IQ
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_WAY-1:0]           fetch_valid,
  input  DISPATCH_PACKET_R10K        fetch_packet [N_WAY],
  input  logic [N_WAY-1:0]           fetch_is_branch,
  input  logic [N_WAY-1:0]           dispatched,
  input  logic                       flush,
  output logic                       fetch_ready,
  output DISPATCH_PACKET_R10K        dispatch_packet [N_WAY],
  output logic [N_WAY-1:0]           branch_inst,
  output logic [$clog2(N_IQ):0]      iq_count
);

  localparam int PW = $clog2(N_IQ);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(N_WAY) + 1;

  DISPATCH_PACKET_R10K mem [N_IQ];
  logic [N_IQ-1:0]     br_mem;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [LW-1:0]       push_raw;
  logic [LW-1:0]       pop_raw;
  logic [CW-1:0]       push_cnt;
  logic [CW-1:0]       pop_cnt;

  lead_ones_count #(.W(N_WAY)) u_push_count (
    .mask  (fetch_valid),
    .count (push_raw)
  );

  lead_ones_count #(.W(N_WAY)) u_pop_count (
    .mask  (dispatched),
    .count (pop_raw)
  );

  // Room for a full group is judged on the registered count alone, so a
  // same-cycle pop never lengthens the fetch_ready path.
  assign fetch_ready = (count <= CW'(N_IQ - N_WAY));
  assign push_cnt    = fetch_ready ? CW'(push_raw) : '0;
  assign pop_cnt     = (CW'(pop_raw) > count) ? count : CW'(pop_raw);
  assign iq_count    = count;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + push_cnt - pop_cnt;
    end
  end

  // NOTE: payload storage has no reset; validity comes only from count, so
  // clearing the array would cost reset fan-out without changing behaviour.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (CW'(i) < push_cnt) begin
          mem[tail + PW'(i)]    <= fetch_packet[i];
          br_mem[tail + PW'(i)] <= fetch_is_branch[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_WAY; i++) begin
      dispatch_packet[i]       = mem[head + PW'(i)];
      dispatch_packet[i].valid = (CW'(i) < count);
      branch_inst[i]           = br_mem[head + PW'(i)] & (CW'(i) < count);
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue (N_WAY=2, N_IQ=8): directed corner
// cases plus randomized traffic against a queue-based reference model.
module tb_dispatch_queue;
  import sys_defs::DISPATCH_PACKET_R10K;

  localparam int NW = 2;
  localparam int NQ = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
  } ent_t;

  logic                clock;
  logic                reset;
  logic [NW-1:0]       fetch_valid;
  DISPATCH_PACKET_R10K fetch_packet [NW];
  logic [NW-1:0]       fetch_is_branch;
  logic [NW-1:0]       dispatched;
  logic                flush;
  logic                fetch_ready;
  DISPATCH_PACKET_R10K dispatch_packet [NW];
  logic [NW-1:0]       branch_inst;
  logic [3:0]          iq_count;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  dispatch_queue #(.N_WAY(NW), .N_IQ(NQ)) dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_packet    (fetch_packet),
    .fetch_is_branch (fetch_is_branch),
    .dispatched      (dispatched),
    .flush           (flush),
    .fetch_ready     (fetch_ready),
    .dispatch_packet (dispatch_packet),
    .branch_inst     (branch_inst),
    .iq_count        (iq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one cycle of stimulus with fresh random payloads, advances the
  // reference queue by the same cycle, then waits until just past the edge.
  task automatic drive(input logic [1:0] fv, input logic [1:0] disp, input logic fl);
    int   pop;
    int   push;
    ent_t e;
    fetch_valid = fv;
    dispatched  = disp;
    flush       = fl;
    for (int i = 0; i < NW; i++) begin
      fetch_packet[i].valid    = fv[i];
      fetch_packet[i].pc       = $urandom;
      fetch_packet[i].inst     = $urandom;
      fetch_packet[i].dest_reg = 5'($urandom);
      fetch_is_branch[i]       = 1'($urandom);
    end
    if (fl) begin
      q.delete();
    end else begin
      pop = 0;
      while (pop < NW && disp[pop]) pop++;
      if (pop > q.size()) pop = q.size();
      push = 0;
      if (NQ - q.size() >= NW)
        while (push < NW && fv[push]) push++;
      repeat (pop) void'(q.pop_front());
      for (int k = 0; k < push; k++) begin
        e.pc   = fetch_packet[k].pc;
        e.inst = fetch_packet[k].inst;
        e.br   = fetch_is_branch[k];
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] fv);
    reset       = 1'b1;
    fetch_valid = fv;
    dispatched  = 2'b00;
    flush       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    q.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2'b00);
    checks++;
    if (iq_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", iq_count); end
    checks++;
    if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", fetch_ready); end
    checks++;
    if (dispatch_packet[0].valid !== 1'b0 || dispatch_packet[1].valid !== 1'b0 || branch_inst !== 2'b00) begin
      errors++;
      $display("FAIL reset_slots: got valid %b%b branch %b expected 00 00",
               dispatch_packet[1].valid, dispatch_packet[0].valid, branch_inst);
    end
    // Reset arriving with a queued group and a new offer: everything is lost.
    drive(2'b11, 2'b00, 1'b0);
    do_reset(2'b11);
    checks++;
    if (iq_count !== 4'd0 || dispatch_packet[0].valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got count %0d valid0 %b expected 0 0", iq_count, dispatch_packet[0].valid);
    end
  endtask

  task automatic test_fill;
    logic [31:0] oldest;
    do_reset(2'b00);
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 1'b0);
      checks++;
      if (iq_count !== 4'(2 * (k + 1))) begin
        errors++; $display("FAIL fill_count%0d: got %0d expected %0d", k, iq_count, 2 * (k + 1));
      end
      checks++;
      if (fetch_ready !== (k < 3)) begin
        errors++; $display("FAIL fill_ready%0d: got %b expected %b", k, fetch_ready, (k < 3));
      end
    end
    oldest = q[0].pc;
    drive(2'b11, 2'b00, 1'b0);
    checks++;
    if (iq_count !== 4'd8) begin errors++; $display("FAIL fill_drop_count: got %0d expected 8", iq_count); end
    checks++;
    if (dispatch_packet[0].pc !== oldest) begin
      errors++; $display("FAIL fill_drop_head: got %h expected %h", dispatch_packet[0].pc, oldest);
    end
  endtask

  task automatic test_push_pop;
    logic [31:0] second;
    do_reset(2'b00);
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 1'b0);
    second = q[1].pc;
    drive(2'b11, 2'b01, 1'b0);
    checks++;
    if (iq_count !== 4'd4) begin errors++; $display("FAIL pushpop_count: got %0d expected 4", iq_count); end
    checks++;
    if (dispatch_packet[0].pc !== second) begin
      errors++; $display("FAIL pushpop_slot0: got %h expected %h", dispatch_packet[0].pc, second);
    end
  endtask

  task automatic test_wrap;
    do_reset(2'b00);
    drive(2'b01, 2'b00, 1'b0);
    repeat (6) drive(2'b01, 2'b01, 1'b0);
    drive(2'b00, 2'b01, 1'b0);
    checks++;
    if (iq_count !== 4'd0) begin errors++; $display("FAIL wrap_empty: got %0d expected 0", iq_count); end
    drive(2'b11, 2'b00, 1'b0);
    checks++;
    if (dispatch_packet[0].pc !== fetch_packet[0].pc || dispatch_packet[1].pc !== fetch_packet[1].pc) begin
      errors++;
      $display("FAIL wrap_slots: got %h %h expected %h %h", dispatch_packet[0].pc, dispatch_packet[1].pc,
               fetch_packet[0].pc, fetch_packet[1].pc);
    end
    checks++;
    if (branch_inst !== fetch_is_branch) begin
      errors++; $display("FAIL wrap_branch: got %b expected %b", branch_inst, fetch_is_branch);
    end
  endtask

  task automatic test_pop_cap;
    do_reset(2'b00);
    drive(2'b01, 2'b00, 1'b0);
    drive(2'b00, 2'b11, 1'b0);
    checks++;
    if (iq_count !== 4'd0) begin errors++; $display("FAIL popcap_count: got %0d expected 0", iq_count); end
    checks++;
    if (dispatch_packet[0].valid !== 1'b0 || dispatch_packet[1].valid !== 1'b0 || branch_inst !== 2'b00) begin
      errors++;
      $display("FAIL popcap_slots: got valid %b%b branch %b expected 00 00",
               dispatch_packet[1].valid, dispatch_packet[0].valid, branch_inst);
    end
  endtask

  task automatic test_flush;
    do_reset(2'b00);
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 1'b0);
    drive(2'b11, 2'b11, 1'b1);
    checks++;
    if (iq_count !== 4'd0 || fetch_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got count %0d ready %b expected 0 1", iq_count, fetch_ready);
    end
    checks++;
    if (dispatch_packet[0].valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b expected 0", dispatch_packet[0].valid);
    end
    drive(2'b01, 2'b00, 1'b0);
    checks++;
    if (iq_count !== 4'd1 || dispatch_packet[0].pc !== fetch_packet[0].pc || dispatch_packet[1].valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_refill: got count %0d pc %h valid1 %b expected 1 %h 0",
               iq_count, dispatch_packet[0].pc, dispatch_packet[1].valid, fetch_packet[0].pc);
    end
  endtask

  task automatic test_non_prefix;
    do_reset(2'b00);
    drive(2'b10, 2'b00, 1'b0);
    checks++;
    if (iq_count !== 4'd0) begin errors++; $display("FAIL nonprefix_push: got %0d expected 0", iq_count); end
    drive(2'b11, 2'b00, 1'b0);
    drive(2'b00, 2'b10, 1'b0);
    checks++;
    if (iq_count !== 4'd2) begin errors++; $display("FAIL nonprefix_pop: got %0d expected 2", iq_count); end
    checks++;
    if (dispatch_packet[0].pc !== q[0].pc) begin
      errors++; $display("FAIL nonprefix_head: got %h expected %h", dispatch_packet[0].pc, q[0].pc);
    end
  endtask

  task automatic test_random;
    logic exp_v;
    logic exp_b;
    do_reset(2'b00);
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom), 2'($urandom), ($urandom_range(0, 19) == 0));
      checks++;
      if (iq_count !== 4'(q.size())) begin
        errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, iq_count, q.size());
      end
      checks++;
      if (fetch_ready !== (q.size() <= NQ - NW)) begin
        errors++; $display("FAIL rand_ready@%0d: got %b expected %b", n, fetch_ready, (q.size() <= NQ - NW));
      end
      for (int i = 0; i < NW; i++) begin
        exp_v = (i < q.size());
        exp_b = exp_v ? q[i].br : 1'b0;
        checks++;
        if (dispatch_packet[i].valid !== exp_v || branch_inst[i] !== exp_b) begin
          errors++;
          $display("FAIL rand_slot%0d@%0d: got valid %b branch %b expected %b %b",
                   i, n, dispatch_packet[i].valid, branch_inst[i], exp_v, exp_b);
        end
        if (exp_v) begin
          checks++;
          if (dispatch_packet[i].pc !== q[i].pc || dispatch_packet[i].inst !== q[i].inst) begin
            errors++;
            $display("FAIL rand_data%0d@%0d: got %h/%h expected %h/%h", i, n,
                     dispatch_packet[i].pc, dispatch_packet[i].inst, q[i].pc, q[i].inst);
          end
        end
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    fetch_valid = '0;
    dispatched  = '0;
    flush       = 1'b0;
    for (int i = 0; i < NW; i++) begin
      fetch_packet[i]    = '0;
      fetch_is_branch[i] = 1'b0;
    end
    test_reset();
    test_fill();
    test_push_pop();
    test_wrap();
    test_pop_cap();
    test_flush();
    test_non_prefix();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
